// File: rtl/alu_pkg.sv
// Shared constants for the ALU result-steering datapath: lane count, select
// width, lane roles and a lane-occupancy popcount helper.
package alu_pkg;

  localparam int LANES      = 4;
  localparam int SEL_W      = 2;

  localparam int LANE_ACC   = 0;
  localparam int LANE_FLAGS = 1;
  localparam int LANE_MEM   = 2;
  localparam int LANE_DBG   = 3;

  typedef logic [SEL_W-1:0] lane_sel_t;
  typedef logic [LANES-1:0] lane_vec_t;

  function automatic logic [2:0] popcount4(input lane_vec_t v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One demux lane: a single-entry holding register with a valid bit.
// The data register keeps its last word after a drain; only valid clears.
module demux_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      if (load) q <= d;
      // load wins over drain so a same-edge drain+load keeps the lane full
      valid <= load | (valid & ~drain);
    end
  end

endmodule

// File: rtl/demux_4x1_reg.sv
// Registered 1-to-4 demultiplexer steering the ALU result stream to one of
// four consumer lanes, each with its own one-entry holding register.
module demux_4x1_reg
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [W-1:0]     in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [4*W-1:0]   out_data,
  output logic [2:0]       lane_busy_cnt
);

  lane_vec_t load;
  lane_vec_t drain;
  lane_vec_t nxt_valid;

  // A full lane can still accept when its consumer takes the old word this edge.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

  always_comb begin
    load = '0;
    if (in_valid && in_ready) load[in_sel] = 1'b1;
  end

  assign drain     = out_valid & out_ready;
  assign nxt_valid = load | (out_valid & ~drain);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane #(.W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .drain (drain[k]),
      .d     (in_data),
      .q     (out_data[k*W +: W]),
      .valid (out_valid[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lane_busy_cnt <= '0;
    else        lane_busy_cnt <= popcount4(nxt_valid);
  end

endmodule

// File: tb/tb_demux_4x1_reg.sv
// Directed bench for demux_4x1_reg: vector table plus a streaming sequence.
module tb_demux_4x1_reg;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [2:0]  lane_busy_cnt;

  always #5 clk = ~clk;

  demux_4x1_reg #(.W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sel        (in_sel),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .lane_busy_cnt (lane_busy_cnt)
  );

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  ordy;
    logic        chk_rdy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [2:0]  exp_cnt;
    logic [31:0] exp_od;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void add(logic r, logic iv, logic [1:0] sel, logic [7:0] d,
                              logic [3:0] ordy, logic chk_rdy, logic exp_rdy,
                              logic [3:0] exp_ov, logic [2:0] exp_cnt,
                              logic [31:0] exp_od);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.sel = sel; v.data = d; v.ordy = ordy;
    v.chk_rdy = chk_rdy; v.exp_rdy = exp_rdy; v.exp_ov = exp_ov;
    v.exp_cnt = exp_cnt; v.exp_od = exp_od;
    vq.push_back(v);
  endfunction

  task automatic drive(logic r, logic iv, logic [1:0] sel, logic [7:0] d, logic [3:0] ordy);
    @(negedge clk);
    rst_n     = r;
    in_valid  = iv;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic check_out(string tag, logic [3:0] ov, logic [2:0] cnt, logic [31:0] od);
    if (out_valid !== ov) begin
      n_miss++;
      $display("FAIL %s out_valid got %b want %b", tag, out_valid, ov);
    end
    if (lane_busy_cnt !== cnt) begin
      n_miss++;
      $display("FAIL %s lane_busy_cnt got %0d want %0d", tag, lane_busy_cnt, cnt);
    end
    if (out_data !== od) begin
      n_miss++;
      $display("FAIL %s out_data got %h want %h", tag, out_data, od);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;

    // reset held two cycles with in_valid high
    add(0, 1, 0, 8'hFF, 4'h0, 0, 1, 4'b0000, 0, 32'h0000_0000);
    add(0, 1, 0, 8'hFF, 4'h0, 1, 1, 4'b0000, 0, 32'h0000_0000);
    // routing, all consumers ready
    add(1, 1, 0, 8'h11, 4'hF, 1, 1, 4'b0001, 1, 32'h0000_0011);
    add(1, 1, 1, 8'h22, 4'hF, 1, 1, 4'b0010, 1, 32'h0000_2211);
    add(1, 1, 2, 8'h33, 4'hF, 1, 1, 4'b0100, 1, 32'h0033_2211);
    add(1, 1, 3, 8'h44, 4'hF, 1, 1, 4'b1000, 1, 32'h4433_2211);
    add(1, 0, 3, 8'h00, 4'hF, 1, 1, 4'b0000, 0, 32'h4433_2211);
    // backpressure isolation on lane 2
    add(1, 1, 2, 8'hA5, 4'h0, 1, 1, 4'b0100, 1, 32'h44A5_2211);
    add(1, 1, 2, 8'h5A, 4'h0, 1, 0, 4'b0100, 1, 32'h44A5_2211);
    add(1, 1, 0, 8'h3C, 4'h0, 1, 1, 4'b0101, 2, 32'h44A5_223C);
    add(1, 1, 2, 8'h5A, 4'h4, 1, 1, 4'b0101, 2, 32'h445A_223C);
    // fill remaining lanes, then every select must stall
    add(1, 1, 1, 8'hB1, 4'h0, 1, 1, 4'b0111, 3, 32'h445A_B13C);
    add(1, 1, 3, 8'hD3, 4'h0, 1, 1, 4'b1111, 4, 32'hD35A_B13C);
    add(1, 1, 0, 8'hEE, 4'h0, 1, 0, 4'b1111, 4, 32'hD35A_B13C);
    add(1, 1, 1, 8'hEE, 4'h0, 1, 0, 4'b1111, 4, 32'hD35A_B13C);
    add(1, 1, 2, 8'hEE, 4'h0, 1, 0, 4'b1111, 4, 32'hD35A_B13C);
    add(1, 1, 3, 8'hEE, 4'h0, 1, 0, 4'b1111, 4, 32'hD35A_B13C);
    // drain lanes 1 and 3 together; data registers keep their words
    add(1, 0, 0, 8'h00, 4'b1010, 1, 0, 4'b0101, 2, 32'hD35A_B13C);
    // reset with lanes 0 and 2 full, then confirm nothing stale appears
    add(0, 0, 0, 8'h00, 4'h0, 1, 0, 4'b0000, 0, 32'h0000_0000);
    add(1, 0, 0, 8'h00, 4'hF, 1, 1, 4'b0000, 0, 32'h0000_0000);

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].iv, vq[i].sel, vq[i].data, vq[i].ordy);
      n_vec++;
      if (vq[i].chk_rdy && in_ready !== vq[i].exp_rdy) begin
        n_miss++;
        $display("FAIL vec%0d in_ready got %b want %b", i, in_ready, vq[i].exp_rdy);
      end
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i), vq[i].exp_ov, vq[i].exp_cnt, vq[i].exp_od);
    end

    // streaming 16 words through the debug lane, one per cycle
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 2'(LANE_DBG), 8'(i), 4'b1000);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_miss++;
        $display("FAIL stream%0d in_ready got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      check_out($sformatf("stream%0d", i), 4'b1000, 3'd1, {8'(i), 24'h00_0000});
    end
    drive(1, 0, 2'(LANE_DBG), 8'h00, 4'b1000);
    n_vec++;
    @(posedge clk); #1;
    check_out("stream_end", 4'b0000, 3'd0, 32'h0F00_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/demux_4x1_reg.md
Name: demux_4x1_reg

Overview:
- Registered 1-to-4 demultiplexer: the inverse of the 4-to-1 input mux in the ALU datapath.
- Steers one W-bit producer stream (ALU result) to one of four consumer lanes, chosen by a 2-bit select.
- Valid/ready handshake on both sides.
- Each lane has a one-entry holding register, so a stalled lane never blocks the other three lanes.
- Sits between the ALU result stage and the four destination consumers (accumulator, flags unit, memory write port, debug tap).

Parameters:
- W, 8, data width in bits of in_data and each lane of out_data.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  producer presents in_data/in_sel this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_sel  input  2  destination lane; 00→lane0, 01→lane1, 10→lane2, 11→lane3.
- in_data  input  W  data to route.
- out_valid  output  4  bit k set means lane k holds data.
- out_ready  input  4  bit k set means consumer k takes lane k this cycle.
- out_data  output  4*W  lane k is bits [k*W +: W]; registered.
- lane_busy_cnt  output  3  number of lanes currently holding data (0..4).

Behaviour:
- Reset:
  - Synchronous, active-low: rst_n=0 at a rising edge of clk clears all lanes.
  - After reset: out_valid=0000, out_data=0, lane_busy_cnt=0.
  - in_ready is combinational and reads 1 once reset is released.
  - Reset asserted mid-transfer discards all held data; no partial state survives.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready at a clock edge.
  - Lane k output transfer occurs when out_valid[k] && out_ready[k] at a clock edge.
- in_ready:
  - in_ready = !full[in_sel] || out_ready[in_sel], where full[k] = out_valid[k].
  - It is a function of in_sel, so it is meaningful only while in_valid=1; the producer must hold in_sel/in_data stable until accepted.
- Latency: data accepted at edge N appears on out_data lane k with out_valid[k]=1 after edge N, i.e. one cycle.
- Lane k, per clock edge:
  - Load (input transfer with in_sel=k): register in_data, set valid.
  - Drain only (output transfer on k, no load): clear valid. out_data lane k holds its last value; it is not zeroed.
  - Simultaneous drain and load on the same lane: the old word leaves, the new word is registered, valid stays 1. Full-throughput pass-through, one word per cycle per lane.
  - Lanes are independent: any subset of lanes may drain in the same cycle as a load to a different lane.
- Ordering: words to the same lane are delivered in acceptance order. No ordering is guaranteed across lanes.
- No dropping or overwriting: a load into a full lane that is not draining is impossible because in_ready=0.
- lane_busy_cnt:
  - Registered population count of out_valid, updated on the same edge as out_valid.
  - Never exceeds 4 and never wraps.
- Unused select encodings: none; all four codes are valid.
- X-safety: in_sel and in_data are ignored when in_valid=0.

Decomposition:
- Shared package alu_pkg:
  - LANES=4.
  - SEL_W=2.
  - Lane-index constants LANE_ACC=0, LANE_FLAGS=1, LANE_MEM=2, LANE_DBG=3.
- Sub-module demux_lane, instantiated 4 times: one holding register plus valid bit.
  - Inputs: clk, rst_n, load, drain, d.
  - Outputs: q, valid.
- Top level contains:
  - The 2-to-4 select decode producing a one-hot load vector.
  - The in_ready mux.
  - The popcount register.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 → out_valid=0000, lane_busy_cnt=0, out_data=0. Then rst_n=1 → in_ready=1.
- Routing, W=8, all out_ready=1: send 0x11/sel0, 0x22/sel1, 0x33/sel2, 0x44/sel3 on consecutive cycles → each word appears one cycle later on its lane only, with a single out_valid bit set. in_ready stays 1 throughout.
- Backpressure isolation: out_ready=0000; send 0xA5 to sel2, then 0x5A to sel2 → second word stalls with in_ready=0. While it stalls, 0x3C to sel0 is accepted. lane_busy_cnt=2. Raise out_ready[2] → 0xA5 drains and 0x5A loads on the same edge; lane2 stays valid.
- Full occupancy: fill all four lanes with out_ready=0000 → lane_busy_cnt=4, in_ready=0 for every sel. Then drain lane1 and lane3 together → lane_busy_cnt=2.
- Streaming: 16 back-to-back words 0x00..0x0F to sel3 with out_ready[3]=1 → one word per cycle, in order, no bubbles, lane_busy_cnt constant at 1.
- Reset mid-operation: lanes 0 and 2 full; pulse rst_n=0 for one cycle → out_valid=0000 and lane_busy_cnt=0 on the next cycle, with no stale data delivered afterwards.
